// File: rtl/uart_tx_fifo_if.sv
// Producer/uart-side bundle for uart_tx_fifo. The master side is whatever drives bytes in
// and owns the uart busy flag; the slave side is the FIFO itself.
interface uart_tx_fifo_if #(
    parameter int DEPTH_LOG2 = 4
);
    logic                  wr_en;
    logic [7:0]            wr_data;
    logic                  full;
    logic                  empty;
    logic [DEPTH_LOG2:0]   count;
    logic                  overflow;
    logic [15:0]           tx_sent;
    logic                  uart_transmit;
    logic [7:0]            uart_tx_byte;
    logic                  uart_is_transmitting;

    // Handshake: a byte is accepted on any clock edge where wr_en=1 and full=0; a byte is
    // handed to the uart on the edge that raises uart_transmit, which then stays high for
    // exactly one cycle with uart_tx_byte valid, and is never raised while the uart is busy.
    modport master (
        output wr_en, wr_data, uart_is_transmitting,
        input  full, empty, count, overflow, tx_sent, uart_transmit, uart_tx_byte
    );

    modport slave (
        input  wr_en, wr_data, uart_is_transmitting,
        output full, empty, count, overflow, tx_sent, uart_transmit, uart_tx_byte
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// Circular byte FIFO feeding a uart transmitter one byte at a time, paced on the uart's
// busy flag so producers can push up to one byte per clock without stalling.
module uart_tx_fifo #(
    parameter int DEPTH_LOG2   = 4,
    parameter int BUSY_TIMEOUT = 4
) (
    input  logic               clk,
    input  logic               rst,
    uart_tx_fifo_if.slave      bus,
    output logic [1:0]         state_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    localparam logic [DEPTH_LOG2:0]   CNT_ONE    = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_FULL   = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE    = DEPTH_LOG2'(1);
    localparam logic [7:0]            TIMER_LAST = 8'(BUSY_TIMEOUT - 1);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic [15:0]           tx_sent_q, tx_sent_d;
    logic                  transmit_q, transmit_d;
    logic [7:0]            tx_byte_q, tx_byte_d;
    logic [7:0]            timer_q, timer_d;
    logic [7:0]            mem_q [DEPTH];

    logic full_w;
    logic empty_w;
    logic push_w;
    logic pop_w;

    // Occupancy flags come from the registered count, so a byte pushed this edge is only
    // seen by the launch logic on the next one.
    assign full_w  = (count_q == CNT_FULL);
    assign empty_w = (count_q == '0);
    assign push_w  = bus.wr_en && !full_w;

    // Transmit sequencer: launch, wait for the uart to go busy (bounded), wait for idle.
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        transmit_d = 1'b0;
        tx_byte_d  = tx_byte_q;
        pop_w      = 1'b0;
        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (!empty_w && !bus.uart_is_transmitting) begin
                    pop_w      = 1'b1;
                    transmit_d = 1'b1;
                    tx_byte_d  = mem_q[rd_ptr_q];
                    state_d    = WAIT_BUSY;
                end
            end
            WAIT_BUSY: begin
                if (bus.uart_is_transmitting) begin
                    state_d = WAIT_DONE;
                    timer_d = '0;
                end else if (timer_q == TIMER_LAST) begin
                    // The uart never acknowledged; the byte still counts as sent.
                    state_d = IDLE;
                    timer_d = '0;
                end else begin
                    timer_d = timer_q + 8'd1;
                end
            end
            WAIT_DONE: begin
                if (!bus.uart_is_transmitting) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                timer_d = '0;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        tx_sent_d  = tx_sent_q;
        if (push_w) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop_w) begin
            rd_ptr_d  = rd_ptr_q + PTR_ONE;
            tx_sent_d = tx_sent_q + 16'd1;
        end
        // A same-cycle pop never makes room for a push against a full FIFO.
        if (bus.wr_en && full_w) begin
            overflow_d = 1'b1;
        end
        case ({push_w, pop_w})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            tx_sent_q  <= '0;
            transmit_q <= 1'b0;
            tx_byte_q  <= '0;
            timer_q    <= '0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            tx_sent_q  <= tx_sent_d;
            transmit_q <= transmit_d;
            tx_byte_q  <= tx_byte_d;
            timer_q    <= timer_d;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (!rst && push_w) begin
            mem_q[wr_ptr_q] <= bus.wr_data;
        end
    end

    assign bus.full          = full_w;
    assign bus.empty         = empty_w;
    assign bus.count         = count_q;
    assign bus.overflow      = overflow_q;
    assign bus.tx_sent       = tx_sent_q;
    assign bus.uart_transmit = transmit_q;
    assign bus.uart_tx_byte  = tx_byte_q;
    assign state_o           = state_q;

    a_strobe_one_cycle: assert property (@(posedge clk) disable iff (rst)
        transmit_q |=> !transmit_q);
    a_count_bound: assert property (@(posedge clk) disable iff (rst)
        count_q <= CNT_FULL);
    a_strobe_leaves_idle: assert property (@(posedge clk) disable iff (rst)
        transmit_q |-> state_q == WAIT_BUSY);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench for uart_tx_fifo with a small behavioural uart and an in-order byte scoreboard.
module tb_uart_tx_fifo;

    localparam int DEPTH_LOG2   = 4;
    localparam int BUSY_TIMEOUT = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [1:0] state;

    uart_tx_fifo_if #(.DEPTH_LOG2(DEPTH_LOG2)) bus_if ();

    uart_tx_fifo #(
        .DEPTH_LOG2  (DEPTH_LOG2),
        .BUSY_TIMEOUT(BUSY_TIMEOUT)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .bus    (bus_if),
        .state_o(state)
    );

    always #5 clk = ~clk;

    int         n_checks  = 0;
    int         n_errors  = 0;
    int         cyc       = 0;
    int         model_mode = 0;   // 0: never busy, 1: busy 3 cycles per strobe, 2: always busy
    int         busy_rem  = 0;
    int         peak_count = 0;
    logic       prev_strobe = 1'b0;
    logic [7:0] mon_exp;
    logic [7:0] exp_q [$];

    always @(posedge clk) cyc++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Uart model: reacts just after each falling edge so the DUT samples a settled flag.
    initial begin
        bus_if.uart_is_transmitting = 1'b0;
        forever begin
            @(negedge clk);
            #1;
            if (model_mode == 1 && bus_if.uart_transmit === 1'b1) busy_rem = 3;
            else if (busy_rem > 0) busy_rem--;
            bus_if.uart_is_transmitting = (model_mode == 2) || (busy_rem > 0);
        end
    end

    // Strobe monitor: every strobe must be one cycle wide and carry the next expected byte.
    initial begin
        forever begin
            @(negedge clk);
            if (bus_if.uart_transmit === 1'b1) begin
                check("strobe_width", 32'(prev_strobe), 32'd0);
                if (exp_q.size() == 0) begin
                    check("unexpected_strobe", 32'd1, 32'd0);
                end else begin
                    mon_exp = exp_q.pop_front();
                    check("tx_byte", 32'(bus_if.uart_tx_byte), 32'(mon_exp));
                end
            end
            prev_strobe = bus_if.uart_transmit;
            if (int'(bus_if.count) > peak_count) peak_count = int'(bus_if.count);
        end
    end

    task automatic push(input logic [7:0] d, input bit stored);
        bus_if.wr_en   = 1'b1;
        bus_if.wr_data = d;
        if (stored) exp_q.push_back(d);
        @(negedge clk);
        bus_if.wr_en   = 1'b0;
    endtask

    task automatic do_reset(input int mode);
        rst        = 1'b1;
        model_mode = mode;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        peak_count = 0;
    endtask

    task automatic wait_drain(input string tag, input int budget);
        bit ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if (bus_if.empty && state == 2'd0 && !bus_if.uart_is_transmitting) begin
                ok = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check(tag, 32'(ok), 32'd1);
    endtask

    task automatic wait_strobe(input string tag, input int budget, output int at);
        bit ok = 1'b0;
        at = -1;
        for (int i = 0; i < budget; i++) begin
            if (bus_if.uart_transmit === 1'b1) begin
                ok = 1'b1;
                at = cyc;
                break;
            end
            @(negedge clk);
        end
        check(tag, 32'(ok), 32'd1);
    endtask

    initial begin
        int t1, t2;
        #100000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t1;
        int t2;
        rst            = 1'b1;
        bus_if.wr_en   = 1'b0;
        bus_if.wr_data = 8'h00;
        @(negedge clk);
        check("rst_empty",    32'(bus_if.empty),         32'd1);
        check("rst_full",     32'(bus_if.full),          32'd0);
        check("rst_count",    32'(bus_if.count),         32'd0);
        check("rst_overflow", 32'(bus_if.overflow),      32'd0);
        check("rst_tx_sent",  32'(bus_if.tx_sent),       32'd0);
        check("rst_strobe",   32'(bus_if.uart_transmit), 32'd0);
        check("rst_tx_byte",  32'(bus_if.uart_tx_byte),  32'd0);
        check("rst_state",    32'(state),                32'd0);
        rst        = 1'b0;
        model_mode = 1;

        // Single byte: visible after the write edge, launched on the next one.
        push(8'h41, 1'b1);
        check("t1_empty_after_push", 32'(bus_if.empty), 32'd0);
        check("t1_count_after_push", 32'(bus_if.count), 32'd1);
        check("t1_strobe_early",     32'(bus_if.uart_transmit), 32'd0);
        @(negedge clk);
        check("t1_strobe",    32'(bus_if.uart_transmit), 32'd1);
        check("t1_tx_sent",   32'(bus_if.tx_sent),       32'd1);
        check("t1_empty",     32'(bus_if.empty),         32'd1);
        check("t1_state_wb",  32'(state),                32'd1);
        @(negedge clk);
        check("t1_strobe_off", 32'(bus_if.uart_transmit), 32'd0);
        check("t1_byte_held",  32'(bus_if.uart_tx_byte),  32'h41);
        check("t1_state_wd",   32'(state),                32'd2);
        check("t1_overflow",   32'(bus_if.overflow),      32'd0);
        wait_drain("t1_drain", 50);
        check("t1_queue", 32'(exp_q.size()), 32'd0);

        // "Hello" back to back against a 3-cycle-busy uart.
        do_reset(1);
        push(8'h48, 1'b1);
        push(8'h65, 1'b1);
        push(8'h6C, 1'b1);
        push(8'h6C, 1'b1);
        push(8'h6F, 1'b1);
        wait_drain("t2_drain", 100);
        check("t2_tx_sent", 32'(bus_if.tx_sent), 32'd5);
        check("t2_peak",    32'(peak_count),     32'd4);
        check("t2_queue",   32'(exp_q.size()),   32'd0);

        // Fill while the uart is held busy, overflow, then push-while-full during a launch.
        do_reset(2);
        @(negedge clk);
        for (int i = 0; i < 16; i++) push(8'(i), 1'b1);
        check("t3_full",     32'(bus_if.full),     32'd1);
        check("t3_count16",  32'(bus_if.count),    32'd16);
        check("t3_no_ovf",   32'(bus_if.overflow), 32'd0);
        push(8'h10, 1'b0);
        check("t3_overflow", 32'(bus_if.overflow), 32'd1);
        check("t3_count_kept", 32'(bus_if.count),  32'd16);
        check("t3_no_launch",  32'(bus_if.tx_sent), 32'd0);
        model_mode = 1;
        push(8'hAA, 1'b0);
        check("t4_count15",   32'(bus_if.count),         32'd15);
        check("t4_full_off",  32'(bus_if.full),          32'd0);
        check("t4_strobe",    32'(bus_if.uart_transmit), 32'd1);
        check("t4_overflow",  32'(bus_if.overflow),      32'd1);
        wait_drain("t3_drain", 300);
        check("t3_tx_sent",   32'(bus_if.tx_sent),  32'd16);
        check("t3_ovf_stays", 32'(bus_if.overflow), 32'd1);
        check("t3_queue",     32'(exp_q.size()),    32'd0);

        // Uart that never goes busy: each launch times out of WAIT_BUSY.
        do_reset(0);
        push(8'h55, 1'b1);
        push(8'h66, 1'b1);
        wait_strobe("t5_strobe1", 20, t1);
        @(negedge clk);
        wait_strobe("t5_strobe2", 20, t2);
        check("t5_gap", 32'(t2 - t1), 32'd5);
        wait_drain("t5_drain", 50);
        check("t5_tx_sent", 32'(bus_if.tx_sent), 32'd2);

        // Reset in WAIT_DONE with bytes still queued.
        do_reset(1);
        push(8'h31, 1'b1);
        push(8'h32, 1'b1);
        push(8'h33, 1'b1);
        push(8'h34, 1'b1);
        check("t6_state_wd", 32'(state),        32'd2);
        check("t6_count3",   32'(bus_if.count), 32'd3);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
        check("t6_count",    32'(bus_if.count),         32'd0);
        check("t6_empty",    32'(bus_if.empty),         32'd1);
        check("t6_tx_sent",  32'(bus_if.tx_sent),       32'd0);
        check("t6_strobe",   32'(bus_if.uart_transmit), 32'd0);
        check("t6_overflow", 32'(bus_if.overflow),      32'd0);
        check("t6_state",    32'(state),                32'd0);
        repeat (20) @(negedge clk);
        check("t6_quiet_tx_sent", 32'(bus_if.tx_sent), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
Byte-stream transmit buffer that sits directly upstream of the uart block. It accepts bytes from design logic at up to one per clock and stores them in a circular FIFO. It feeds them one at a time to the uart's transmit / tx_byte inputs, pacing on the uart's is_transmitting output, so producers never stall on the serial line.

Parameters:
DEPTH_LOG2, 4, log2 of FIFO depth (depth = 2**DEPTH_LOG2 = 16 entries)
BUSY_TIMEOUT, 4, max cycles spent in WAIT_BUSY before giving up on busy rising (range 1..255)

Ports:
clk  input  1  master clock
rst  input  1  synchronous reset, active-high
wr_en  input  1  push wr_data this cycle
wr_data  input  8  byte to enqueue
full  output  1  FIFO holds 2**DEPTH_LOG2 entries
empty  output  1  FIFO holds 0 entries
count  output  DEPTH_LOG2+1  current occupancy
overflow  output  1  sticky: a push was attempted while full
tx_sent  output  16  bytes handed to uart, wraps 0xFFFF->0x0000
uart_transmit  output  1  one-cycle launch strobe to uart transmit
uart_tx_byte  output  8  byte to uart tx_byte, valid while uart_transmit=1
uart_is_transmitting  input  1  uart busy flag

Behaviour:
- Reset is clk, rst: synchronous, active-high, and dominates all other inputs. Effects: rd_ptr=wr_ptr=0, count=0, empty=1, full=0, overflow=0, tx_sent=0, uart_transmit=0, uart_tx_byte=0, state=IDLE. The storage array is not cleared.
- All outputs are registered. full/empty/count derive from the registered count.
- Push: when wr_en=1 and full=0 at the clock edge, mem[wr_ptr]<=wr_data and wr_ptr increments mod depth.
- Push while full: the byte is dropped, pointers are unchanged, and overflow<=1. overflow clears only on rst.
- Push and pop in the same cycle: both take effect and count is unchanged. A pop does not free space for a push in the same cycle, so a push while full is still dropped.
- Pointers are DEPTH_LOG2 bits wide and wrap naturally. count is updated as +1 (push only), -1 (pop only), or 0.
- FSM states: IDLE, WAIT_BUSY, WAIT_DONE.
  - IDLE, launch condition: empty=0 and uart_is_transmitting=0. On that edge: uart_transmit<=1, uart_tx_byte<=mem[rd_ptr], rd_ptr increments (pop), tx_sent increments, state<=WAIT_BUSY.
  - IDLE, otherwise: uart_transmit<=0.
  - WAIT_BUSY: uart_transmit<=0 on entry edge+1, so the strobe is exactly 1 cycle wide. A timer counts cycles in this state.
    - uart_is_transmitting=1: state<=WAIT_DONE.
    - Timer reaches BUSY_TIMEOUT: state<=IDLE. The byte counts as sent; no retry.
  - WAIT_DONE: when uart_is_transmitting=0, state<=IDLE.
- Latency and throughput:
  - First byte: written at edge E, it is visible (empty=0) after E. The launch decision is at E+1, and uart_transmit is high during cycle E+1..E+2.
  - Back-to-back: the next launch needs IDLE plus uart idle, so at most one byte is in flight at the uart.
- uart_tx_byte holds its last value after the strobe and changes only on the next launch.
- A byte written into an empty FIFO in the same cycle the FSM evaluates IDLE is not launched that cycle (empty is registered). It launches on the following cycle.
- Reset mid-transfer: the strobe drops at the reset edge and FSM returns to IDLE. Any byte already launched is not recalled, and the uart's own state is the uart's responsibility.
- uart_is_transmitting=1 while in IDLE (busy from a foreign source): no launch until it drops.

Test Plan:
1. Reset, then push 0x41 at cycle 1 with uart idle → uart_transmit high for exactly 1 cycle with uart_tx_byte=0x41; tx_sent=1; empty=1 afterwards; overflow=0.
2. Push 0x48,0x65,0x6C,0x6C,0x6F on consecutive cycles with a model uart (busy 3 cycles per byte) → strobes appear in order "Hello", never while busy, ≥1 idle cycle apart; tx_sent=5; count peaks at 4.
3. Hold uart_is_transmitting=1, push 17 bytes 0x00..0x10 → full=1 and count=16 after the 16th push; the 17th byte (0x10) is dropped and overflow=1. Release busy → bytes 0x00..0x0F drain in order, overflow stays 1.
4. Full FIFO with a simultaneous push (0xAA) and launch → count goes to 15 and 0xAA is not stored; overflow=1.
5. uart model that never asserts busy, 2 bytes queued → each launch leaves WAIT_BUSY after BUSY_TIMEOUT=4 cycles; strobes 5 cycles apart; tx_sent=2.
6. Assert rst for 1 cycle while in WAIT_DONE with 3 bytes queued → next cycle count=0, empty=1, tx_sent=0, uart_transmit=0, overflow=0; no further strobes without new pushes.
